// File: rtl/ens_vote_pkg.sv
// ----------------------------------------------------------------------------
// ens_vote_pkg
// Shared definitions for the ensemble vote / argmax output stage:
//   - vote_state_e : FSM states (ACCUM, SCAN, HOLD)
//   - clog2        : ceiling log2, used to size derived widths
//   - DEF_*        : default parameter values shared with the ensemble wrapper
// ----------------------------------------------------------------------------
package ens_vote_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } vote_state_e;

    localparam int DEF_NUM_MEMBERS = 4;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_SCORE_BITS  = 2;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(10) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v / 2) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ens_vote_acc_bank.sv
// ----------------------------------------------------------------------------
// ens_vote_acc_bank
// NUM_CLASSES unsigned accumulators of ACC_W bits. Each add beat adds the
// per-class score slice of i_scores to the matching accumulator. A synchronous
// clear (or reset) zeroes all of them. One indexed read port serves the
// argmax scan.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_add_en     : add i_scores into the bank this cycle
//   i_clr        : zero every accumulator (wins over i_add_en)
//   i_scores     : class c score at [c*SCORE_BITS +: SCORE_BITS]
//   i_rd_idx     : class index to read
//   o_rd_data    : accumulator value for i_rd_idx (0 if out of range)
// ----------------------------------------------------------------------------
module ens_vote_acc_bank
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_BITS  = DEF_SCORE_BITS,
    parameter int ACC_W       = DEF_SCORE_BITS + 2,
    parameter int IDX_W       = clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_add_en,
    input  logic                              i_clr,
    input  logic [NUM_CLASSES*SCORE_BITS-1:0] i_scores,
    input  logic [IDX_W-1:0]                  i_rd_idx,
    output logic [ACC_W-1:0]                  o_rd_data
);

    logic [ACC_W-1:0] r_acc [NUM_CLASSES];

    // Accumulator update: reset/clear zero the bank, an add beat sums in scores.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_acc[c] <= '0;
            end
        end else if (i_add_en) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_acc[c] <= r_acc[c] + ACC_W'(i_scores[c*SCORE_BITS +: SCORE_BITS]);
            end
        end
    end

    // Indexed read; indices beyond the last class read as zero.
    always_comb begin
        o_rd_data = '0;
        if (int'(i_rd_idx) < NUM_CLASSES) begin
            o_rd_data = r_acc[i_rd_idx];
        end else begin
            o_rd_data = '0;
        end
    end

endmodule

// File: rtl/ens_vote_argmax.sv
// ----------------------------------------------------------------------------
// ens_vote_argmax
// Ensemble output stage. Accepts NUM_MEMBERS class-score vectors (one per
// handshake beat), sums them per class, then scans the sums one class per
// cycle for the maximum (ties go to the lowest index) and presents the
// winner on a valid/ready output.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   s_valid/s_ready     : member vector handshake
//   s_data              : class c score at [c*SCORE_BITS +: SCORE_BITS]
//   m_valid/m_ready     : result handshake
//   m_class, m_score    : winning class index and its summed score
// ----------------------------------------------------------------------------
module ens_vote_argmax
    import ens_vote_pkg::*;
#(
    parameter  int NUM_MEMBERS = DEF_NUM_MEMBERS,
    parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter  int SCORE_BITS  = DEF_SCORE_BITS,
    localparam int ACC_W       = SCORE_BITS + clog2(NUM_MEMBERS),
    localparam int IDX_W       = clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [NUM_CLASSES*SCORE_BITS-1:0] s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [IDX_W-1:0]                  m_class,
    output logic [ACC_W-1:0]                  m_score
);

    localparam int CNT_W = clog2(NUM_MEMBERS);

    vote_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [ACC_W-1:0] r_best_score;
    logic [IDX_W-1:0] r_best_idx;
    logic [IDX_W-1:0] r_m_class;
    logic [ACC_W-1:0] r_m_score;

    logic             w_s_fire;
    logic             w_clr;
    logic [ACC_W-1:0] w_rd_data;
    logic [ACC_W-1:0] w_next_best_score;
    logic [IDX_W-1:0] w_next_best_idx;

    // rst gates s_ready directly so nothing is accepted on the reset edges
    // themselves, before the state register has been forced back to ACCUM.
    assign s_ready  = (r_state == ACCUM) && !rst;
    assign w_s_fire = s_valid && s_ready;
    assign w_clr    = (r_state == HOLD) && m_ready;

    assign m_valid = (r_state == HOLD);
    assign m_class = r_m_class;
    assign m_score = r_m_score;

    ens_vote_acc_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_BITS  (SCORE_BITS),
        .ACC_W       (ACC_W),
        .IDX_W       (IDX_W)
    ) u_acc_bank (
        .clk       (clk),
        .rst       (rst),
        .i_add_en  (w_s_fire),
        .i_clr     (w_clr),
        .i_scores  (s_data),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd_data)
    );

    // Argmax step: index 0 seeds the running best, later indices replace it
    // only when strictly greater so the lowest index wins a tie.
    always_comb begin
        w_next_best_score = r_best_score;
        w_next_best_idx   = r_best_idx;
        if ((r_idx == '0) || (w_rd_data > r_best_score)) begin
            w_next_best_score = w_rd_data;
            w_next_best_idx   = r_idx;
        end else begin
            w_next_best_score = r_best_score;
            w_next_best_idx   = r_best_idx;
        end
    end

    // Control FSM: beat counting, class scan and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ACCUM;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_m_class    <= '0;
            r_m_score    <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_s_fire) begin
                        if (r_cnt == CNT_W'(NUM_MEMBERS - 1)) begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_state <= SCAN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                SCAN: begin
                    r_best_score <= w_next_best_score;
                    r_best_idx   <= w_next_best_idx;
                    if (r_idx == IDX_W'(NUM_CLASSES - 1)) begin
                        // Result is latched from the final comparison so the
                        // outputs are ready on the first HOLD cycle.
                        r_m_class <= w_next_best_idx;
                        r_m_score <= w_next_best_score;
                        r_idx     <= '0;
                        r_state   <= HOLD;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule
